// File: rtl/vdec1_crc_pkg.sv
// Shared constants and FSM state type for the parallel CRC checker.
// Common generator polynomials; the x^CRC_W term is implicit.
package vdec1_crc_pkg;

   localparam logic [15:0] CRC16_POLY  = 16'h1021;
   localparam logic [23:0] CRC24A_POLY = 24'h864CFB;
   localparam logic [23:0] CRC24B_POLY = 24'h800063;
   localparam logic [23:0] CRC24C_POLY = 24'hB2B117;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } crc_state_e;

endpackage

// File: rtl/vdec1_crc_step.sv
// One serial CRC stage (MSB-first, no reflection).
// A disabled stage passes the CRC through, so a chain can stop partway through a word.
module vdec1_crc_step
   import vdec1_crc_pkg::*;
#(
   parameter int               CRC_W = 16,
   parameter logic [CRC_W-1:0] POLY  = CRC16_POLY
) (
   input  logic [CRC_W-1:0] crc_i,
   input  logic             bit_i,
   input  logic             en_i,
   output logic [CRC_W-1:0] crc_o
);

   logic fb;

   always_comb begin
      fb    = crc_i[CRC_W-1] ^ bit_i;
      crc_o = crc_i;
      if (en_i) begin
         crc_o = {crc_i[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
      end
   end

endmodule

// File: rtl/vdec1_crc_check_par.sv
// Multi-bit-per-cycle CRC checker: recomputes the CRC over info_len bits and flags a match.
// Optional macro VDEC1_CRC_MASK_EN XORs crc_mask into the computed CRC before the compare.
module vdec1_crc_check_par
   import vdec1_crc_pkg::*;
#(
   parameter int               INFO_W       = 64,
   parameter int               CRC_W        = 16,
   parameter logic [CRC_W-1:0] POLY         = CRC16_POLY,
   parameter int               BITS_PER_CYC = 1,
   parameter int               LEN_W        = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [INFO_W-1:0] info_bits,
   input  logic [CRC_W-1:0]  crc_bits,
   input  logic [LEN_W-1:0]  info_len,
   input  logic [CRC_W-1:0]  crc_mask,
   output logic              busy,
   output logic              done,
   output logic              crc_match
);

   crc_state_e        state_q;
   logic [INFO_W-1:0] cache_q;
   logic [LEN_W-1:0]  bit_cnt_q;
   logic [CRC_W-1:0]  crc_q;
   logic [CRC_W-1:0]  crc_ref_q;
   logic              busy_q;
   logic              done_q;
   logic              match_q;

   logic [CRC_W-1:0]  chain [BITS_PER_CYC+1];
   logic [CRC_W-1:0]  crc_d;
   logic [CRC_W-1:0]  crc_fin;
   logic [LEN_W-1:0]  bit_cnt_d;
   logic [LEN_W-1:0]  len_clamp;
   logic              last_cyc;

   assign chain[0] = crc_q;

   // Stage k only consumes a bit while at least k+1 bits remain.
   for (genvar k = 0; k < BITS_PER_CYC; k++) begin : g_step
      vdec1_crc_step #(
         .CRC_W (CRC_W),
         .POLY  (POLY)
      ) u_step (
         .crc_i (chain[k]),
         .bit_i (cache_q[k]),
         .en_i  (bit_cnt_q > LEN_W'(k)),
         .crc_o (chain[k+1])
      );
   end

   assign crc_d     = chain[BITS_PER_CYC];
   assign last_cyc  = (bit_cnt_q <= LEN_W'(BITS_PER_CYC));
   assign bit_cnt_d = last_cyc ? '0 : bit_cnt_q - LEN_W'(BITS_PER_CYC);
   assign len_clamp = (info_len > LEN_W'(INFO_W)) ? LEN_W'(INFO_W) : info_len;

`ifdef VDEC1_CRC_MASK_EN
   logic [CRC_W-1:0] mask_q;
   assign crc_fin = crc_d ^ mask_q;
`else
   logic unused_mask;
   assign unused_mask = ^crc_mask;
   assign crc_fin     = crc_d;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cache_q   <= '0;
         bit_cnt_q <= '0;
         crc_q     <= '0;
         crc_ref_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         match_q   <= 1'b0;
`ifdef VDEC1_CRC_MASK_EN
         mask_q    <= '0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  cache_q   <= info_bits;
                  bit_cnt_q <= len_clamp;
                  crc_q     <= '0;
                  crc_ref_q <= crc_bits;
`ifdef VDEC1_CRC_MASK_EN
                  mask_q    <= crc_mask;
`endif
                  match_q   <= 1'b0;
                  busy_q    <= 1'b1;
                  state_q   <= ST_RUN;
               end
            end
            ST_RUN: begin
               crc_q     <= crc_d;
               cache_q   <= cache_q >> BITS_PER_CYC;
               bit_cnt_q <= bit_cnt_d;
               if (last_cyc) begin
                  match_q <= (crc_fin == crc_ref_q);
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign crc_match = match_q;

endmodule
